uart_rx_fsm: RTL and testbench

//   UART receiver, FSM-based: the receive end of the uart_tx_FSM serial link.
//   - Frame: 8N1, LSB first (start=0, 8 data, stop=1); optional even parity bit.
//   - Samples asynchronous RxD on an oversampling tick (rx_en) from a free-running

---
 rtl/uart_rx_fsm_if.sv | 26 ++
 rtl/uart_rx_fsm.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Purpose : bundles the UART receiver's tick, serial input and byte-output signals.
// Ports   : rx_en, RxD (towards receiver); rx_data, rx_valid, rx_frame_err,
//           rx_parity_err, rx_busy, state (from receiver).
// Modports: slave = the receiver itself; master = whatever drives the line and consumes bytes.
interface uart_rx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 RxD;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_busy;
  logic [3:0]           state;

  modport slave (
    input  rx_en, RxD,
    output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy, state
  );

  modport master (
    output rx_en, RxD,
    input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy, state
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// Purpose : FSM-based UART receiver, 8N1 LSB first, optional even parity
//           (enabled by defining UART_RX_PARITY_EN), oversampled by rx_en ticks.
// Latency : rx_valid rises 1 clk after the rx_en tick at mid stop bit.
// Backpressure: none; rx_valid is a 1-clk strobe, rx_data/err flags hold until the next frame.
// Ports   : clk, rst (sync, active-high); bus.slave carries rx_en, RxD in and
//           rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy, state (debug) out.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fsm_if.slave   bus
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // START has already consumed one tick on entry; this many more reach the mid start bit.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 4'd3,
`endif
    S_STOP   = 4'd4
  } state_t;

  logic [1:0]           r_sync;
  state_t               r_state,  w_state_nxt;
  logic [TW-1:0]        r_tick,   w_tick_nxt;
  logic [BW-1:0]        r_bit,    w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
  logic [DATA_BITS-1:0] r_data,   w_data_nxt;
  logic                 r_valid,  w_valid_nxt;
  logic                 r_ferr,   w_ferr_nxt;
  logic                 r_armed,  w_armed_nxt;
  logic                 w_rxd;
`ifdef UART_RX_PARITY_EN
  logic                 r_par,    w_par_nxt;
  logic                 r_perr,   w_perr_nxt;
`endif

  assign w_rxd = r_sync[1];

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = r_ferr;
    w_armed_nxt = r_armed;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = r_perr;
`endif
    if (bus.rx_en) begin
      case (r_state)
        S_IDLE: begin
          // After a frame error the line must be seen high once before a new start is accepted.
          if (w_rxd) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick == HALF_LAST) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rxd ? S_IDLE : S_DATA;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        S_DATA: begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rxd, r_shift[DATA_BITS-1:1]};
            if (r_bit == BIT_LAST) begin
              w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_par_nxt   = w_rxd;
            w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_data_nxt  = r_shift;
            w_ferr_nxt  = ~w_rxd;
            w_valid_nxt = 1'b1;
            w_armed_nxt = w_rxd;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = (^r_shift) != r_par;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], bus.RxD};
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_armed <= w_armed_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  assign bus.rx_data      = r_data;
  assign bus.rx_valid     = r_valid;
  assign bus.rx_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.rx_parity_err = r_perr;
`else
  assign bus.rx_parity_err = 1'b0;
`endif
  assign bus.rx_busy      = (r_state != S_IDLE);
  assign bus.state        = r_state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Purpose : self-checking bench for uart_rx_fsm (table of frames plus corner-case sequences).
// Latency : expected bytes are queued as the stop bit is driven and compared on rx_valid.
// Backpressure: none; the bench drives the serial line at OVERSAMPLE rx_en ticks per bit.
module tb_uart_rx_fsm;
  localparam int OS       = 16;
  localparam int RXEN_DIV = 4;
  localparam int NVEC     = 13;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   en_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;
  vec_t vecs[NVEC];

  uart_rx_fsm_if #(.DATA_BITS(8)) ifc();

  uart_rx_fsm #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running oversampling tick, one clk wide every RXEN_DIV clks.
  initial begin
    ifc.rx_en = 1'b0;
    forever begin
      @(negedge clk);
      en_cnt = (en_cnt + 1) % RXEN_DIV;
      ifc.rx_en = (en_cnt == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.rx_valid === 1'b1) begin
        n_valid++;
        check("valid_width", {31'd0, prev_valid}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got rx_data %0h with no frame queued", ifc.rx_data);
        end else begin
          e = sb.pop_front();
          check("rx_data", {24'd0, ifc.rx_data}, {24'd0, e.d});
          check("frame_err", {31'd0, ifc.rx_frame_err}, {31'd0, e.fe});
          check("parity_err", {31'd0, ifc.rx_parity_err}, {31'd0, e.pe});
        end
      end
      prev_valid = ifc.rx_valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (ifc.rx_en !== 1'b1);
    end
  endtask

  task automatic send_bit(input logic b);
    ifc.RxD = b;
    wait_ticks(OS);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic exp_fe, input logic exp_pe);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_ON) send_bit(par);
    sb.push_back({d, exp_fe, exp_pe});
    send_bit(stop);
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int v0;
    logic [7:0] rnd;
    rst     = 1'b1;
    ifc.RxD = 1'b1;

    // Table: A5, ten random bytes, then 07 with wrong and right even parity.
    vecs[0] = '{8'hA5, ^8'hA5, 1'b1, 1'b0, 1'b0};
    for (int i = 1; i <= 10; i++) begin
      rnd = 8'($urandom_range(0, 255));
      vecs[i] = '{rnd, ^rnd, 1'b1, 1'b0, 1'b0};
    end
    vecs[11] = '{8'h07, 1'b0, 1'b1, 1'b0, PAR_ON};
    vecs[12] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_rx_data", {24'd0, ifc.rx_data}, 32'd0);
    check("rst_valid", {31'd0, ifc.rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, ifc.rx_frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, ifc.rx_parity_err}, 32'd0);
    check("rst_busy", {31'd0, ifc.rx_busy}, 32'd0);
    check("rst_state", {28'd0, ifc.state}, 32'd0);
    rst = 1'b0;

    wait_ticks(2);
    @(negedge clk);

    // Back-to-back frames, no idle gap between stop and next start.
    v0 = n_valid;
    for (int i = 0; i < NVEC; i++)
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].exp_fe, vecs[i].exp_pe);
    drain();
    check("b2b_count", n_valid - v0, NVEC);
    check("hold_rx_data", {24'd0, ifc.rx_data}, 32'h07);
    check("b2b_busy", {31'd0, ifc.rx_busy}, 32'd0);

    // Start-bit glitch: low for 3 ticks only.
    v0 = n_valid;
    ifc.RxD = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    check("glitch_busy_mid", {31'd0, ifc.rx_busy}, 32'd1);
    ifc.RxD = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clk);
    check("glitch_busy", {31'd0, ifc.rx_busy}, 32'd0);
    check("glitch_state", {28'd0, ifc.state}, 32'd0);
    check("glitch_no_valid", n_valid - v0, 0);

    // Break: stop bit 0 then line held low for 30 bit times.
    v0 = n_valid;
    send_frame(8'h55, ^8'h55, 1'b0, 1'b1, 1'b0);
    ifc.RxD = 1'b0;
    wait_ticks(30 * OS);
    @(negedge clk);
    check("break_one_strobe", n_valid - v0, 1);
    check("break_rx_data", {24'd0, ifc.rx_data}, 32'h55);
    check("break_frame_err", {31'd0, ifc.rx_frame_err}, 32'd1);
    check("break_busy", {31'd0, ifc.rx_busy}, 32'd0);
    ifc.RxD = 1'b1;
    wait_ticks(OS);
    @(negedge clk);
    send_frame(8'hC3, ^8'hC3, 1'b1, 1'b0, 1'b0);
    drain();
    check("rearm_frame_err", {31'd0, ifc.rx_frame_err}, 32'd0);

    // Reset pulse at mid data bit 4 of 8'hFF.
    v0 = n_valid;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ifc.RxD = 1'b1;
    wait_ticks(OS / 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(OS - OS / 2);
    @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(1'b1);
    if (PAR_ON) send_bit(1'b0);
    send_bit(1'b1);
    wait_ticks(OS);
    @(negedge clk);
    check("rst_mid_no_valid", n_valid - v0, 0);
    check("rst_mid_rx_data", {24'd0, ifc.rx_data}, 32'd0);
    check("rst_mid_busy", {31'd0, ifc.rx_busy}, 32'd0);
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0, 1'b0);
    drain();
    check("post_rst_rx_data", {24'd0, ifc.rx_data}, 32'h3C);
    check("post_rst_count", n_valid - v0, 1);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
